// File: rtl/fp_convert_seq.sv
// Sequential 12-bit two's-complement to 8-bit float {sign, exp[2:0], mant[3:0]} converter.
// Optional FPCONV_FAST_NORM_EN replaces the shift-per-cycle normalizer with a one-cycle priority encoder.
module fp_convert_seq #(
  parameter int MAX_SHIFT = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  fp_out,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, DONE} state_t;

  state_t      state, state_nxt;
  logic [11:0] din_q;
  logic        sgn;
  logic [10:0] v;
  logic [2:0]  ex;
  logic [7:0]  fp_q;

  logic [11:0] mag;
  logic [4:0]  mant_sum;
  logic        norm_done;

  assign mag      = din_q[11] ? (~din_q + 12'd1) : din_q;
  assign mant_sum = {1'b0, v[10:7]} + {4'b0000, v[6]};

`ifdef FPCONV_FAST_NORM_EN
  logic [2:0]  fexp;
  logic [10:0] fv;

  // Highest set bit in v[10:4] wins; bit p maps to exponent p-3.
  always_comb begin
    fexp = 3'd0;
    for (int i = 4; i <= 10; i++) begin
      if (v[i]) fexp = 3'(i - 3);
    end
    fv = v << (3'd7 - fexp);
  end
  assign norm_done = 1'b1;
`else
  assign norm_done = (ex == 3'd0) || v[10];
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = ABS;
      end
      ABS:   state_nxt = NORM;
      NORM:  if (norm_done) state_nxt = ROUND;
      ROUND: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_q <= 12'h000;
      sgn   <= 1'b0;
      v     <= 11'h000;
      ex    <= 3'd0;
      fp_q  <= 8'h00;
    end else begin
      case (state)
        IDLE: if (in_valid) din_q <= din;
        ABS: begin
          sgn <= din_q[11];
          // -2048 has no 11-bit magnitude; clamp it to the largest one.
          v   <= (din_q == 12'h800) ? 11'h7FF : mag[10:0];
          ex  <= 3'(MAX_SHIFT);
        end
        NORM: begin
`ifdef FPCONV_FAST_NORM_EN
          v  <= fv;
          ex <= fexp;
`else
          if (!norm_done) begin
            v  <= {v[9:0], 1'b0};
            ex <= ex - 3'd1;
          end
`endif
        end
        ROUND: begin
          if (mant_sum[4]) begin
            if (ex != 3'(MAX_SHIFT)) fp_q <= {sgn, ex + 3'd1, 4'b1000};
            else                     fp_q <= {sgn, 3'(MAX_SHIFT), 4'hF};
          end else begin
            fp_q <= {sgn, ex, mant_sum[3:0]};
          end
        end
        default: ;
      endcase
    end
  end

  assign fp_out = fp_q;

endmodule

// File: tb/tb_fp_convert_seq.sv
// Directed + random bench for fp_convert_seq with a result scoreboard and immediate assertions.
module tb_fp_convert_seq;

`ifdef FPCONV_FAST_NORM_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] din;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  fp_out;
  logic        busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] fp;
    int         lat;
  } exp_t;
  exp_t sb[$];

  fp_convert_seq #(.MAX_SHIFT(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .fp_out(fp_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: magnitude, normalize to bit 10 or exp 0, round half up on bit 6.
  function automatic void model(input logic [11:0] d, output logic [7:0] fp, output int k);
    int mag, e, m, mant;
    bit s;
    s   = d[11];
    mag = s ? (4096 - int'(d)) : int'(d);
    if (mag > 2047) mag = 2047;
    e = 7; m = mag; k = 0;
    while (e > 0 && m < 1024) begin
      m = m * 2; e--; k++;
    end
    mant = (m >> 7) + ((m >> 6) & 1);
    if (mant == 16) begin
      if (e < 7) begin mant = 8; e++; end
      else mant = 15;
    end
    fp = {s, 3'(e), 4'(mant)};
  endfunction

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_one(input logic [11:0] d, input logic [7:0] efp, input int k, input bit hold);
    exp_t e;
    int cyc;
    logic [7:0] held;
    e.fp  = efp;
    e.lat = FAST ? 3 : k + 3;
    sb.push_back(e);
    check($sformatf("ready_before_%03h", d), in_ready, 1);
    in_valid = 1'b1; din = d;
    @(posedge clk); #1;
    in_valid = 1'b0; din = 12'h5A5;
    wait_valid(cyc);
    e = sb.pop_front();
    check($sformatf("latency_%03h", d), cyc, e.lat);
    check($sformatf("fp_out_%03h", d), fp_out, e.fp);
    if (hold) begin
      held = fp_out;
      in_valid = 1'b1; din = 12'h123;
      for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
      check("hold_fp", fp_out, held);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_busy", busy, 1);
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check($sformatf("valid_drop_%03h", d), out_valid, 0);
    check($sformatf("idle_ready_%03h", d), in_ready, 1);
    check($sformatf("fp_keep_%03h", d), fp_out, e.fp);
  endtask

  initial begin
    logic [11:0] d;
    logic [7:0]  efp;
    int          k, cyc;
    bit          seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_fp_out", fp_out, 8'h00);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    run_one(12'h01A, 8'h1D, 6, 1'b0);
    run_one(12'h07C, 8'h48, 4, 1'b0);
    run_one(12'h7FF, 8'h7F, 0, 1'b0);
    run_one(12'h800, 8'hFF, 0, 1'b0);
    run_one(12'hFFF, 8'h81, 7, 1'b0);
    run_one(12'h000, 8'h00, 7, 1'b0);
    run_one(12'h3C0, 8'h6F, 1, 1'b1);
    run_one(12'hF80, 8'hC8, 3, 1'b0);

    for (int i = 0; i < 8; i++) begin
      d = 12'($urandom);
      model(d, efp, k);
      run_one(d, efp, k, 1'b0);
    end

    // Reset while normalizing: the partial result must never surface.
    in_valid = 1'b1; din = 12'h001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_norm_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("norm_rst_valid", out_valid, 0);
    check("norm_rst_in_ready", in_ready, 1);
    check("norm_rst_fp", fp_out, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("no_partial_result", seen, 0);

    // Reset while holding a result in DONE.
    in_valid = 1'b1; din = 12'h7FF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(cyc);
    check("done_reached", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("done_rst_valid", out_valid, 0);
    check("done_rst_in_ready", in_ready, 1);
    check("done_rst_busy", busy, 0);

    run_one(12'h01A, 8'h1D, 6, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
